// File: rtl/rr_mux_reg.sv
// N-channel registered multiplexer with round-robin arbitration and valid/ready on every port.
// Define RR_MUX_FIXED_PRIO_EN to replace round-robin with fixed priority (channel 0 highest).
module rr_mux_reg #(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      Enable,
  input  logic [CHANNELS-1:0]       InValid,
  input  logic [CHANNELS*WIDTH-1:0] InData,
  output logic [CHANNELS-1:0]       InReady,
  output logic                      OutValid,
  output logic [WIDTH-1:0]          OutData,
  output logic [SEL_W-1:0]          OutSel,
  input  logic                      OutReady
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_sel;

  logic [SEL_W-1:0] w_start;
  logic [WIDTH-1:0] w_in_data [CHANNELS];
  logic             w_slot_free;
  logic             w_found;
  logic [SEL_W:0]   w_sum;
  logic [SEL_W-1:0] w_scan_idx;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_gnt_valid;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [SEL_W-1:0] r_ptr;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_ptr <= '0;
    end else if (w_gnt_valid) begin
      r_ptr <= (w_gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign w_start = r_ptr;
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_in_data[i] = InData[i*WIDTH +: WIDTH];
    end
  end

  assign w_slot_free = ~r_valid | OutReady;

  // Scan CHANNELS slots starting at w_start, wrapping modulo CHANNELS; first valid wins.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    w_found    = 1'b0;
    w_sum      = '0;
    w_scan_idx = '0;
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_sum = {1'b0, w_start} + (SEL_W + 1)'(k);
      if (w_sum >= (SEL_W + 1)'(CHANNELS)) begin
        w_sum = w_sum - (SEL_W + 1)'(CHANNELS);
      end
      w_scan_idx = w_sum[SEL_W-1:0];
      if (!w_found && InValid[w_scan_idx]) begin
        w_found    = 1'b1;
        w_gnt_idx  = w_scan_idx;
        w_gnt_data = w_in_data[w_scan_idx];
      end
    end
  end

  // Gating with Reset_n keeps a transfer from being honoured in a reset cycle.
  assign w_gnt_valid = Reset_n & Enable & w_slot_free & w_found;

  always_comb begin
    InReady = '0;
    if (w_gnt_valid) begin
      InReady[w_gnt_idx] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_gnt_valid) begin
      r_valid <= 1'b1;
      r_data  <= w_gnt_data;
      r_sel   <= w_gnt_idx;
    end else if (r_valid && OutReady) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end
  end

  assign OutValid = r_valid;
  assign OutData  = r_data;
  assign OutSel   = r_sel;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Self-checking bench for rr_mux_reg: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbitrated output register.
module tb_rr_mux_reg;

  localparam int CH = 4;
  localparam int W  = 32;

  logic          Clock;
  logic          Reset_n;
  logic          Enable;
  logic [CH-1:0] InValid;
  logic [CH*W-1:0] InData;
  logic [CH-1:0] InReady;
  logic          OutValid;
  logic [W-1:0]  OutData;
  logic [1:0]    OutSel;
  logic          OutReady;

  logic [W-1:0]  ch_data [CH];

  int checks   = 0;
  int failures = 0;

  // Model state: contents of the output register and next channel to favour.
  logic          m_valid = 1'b0;
  logic [W-1:0]  m_data  = '0;
  logic [1:0]    m_sel   = '0;
  int            m_ptr   = 0;

  for (genvar i = 0; i < CH; i++) begin : g_pack
    assign InData[i*W +: W] = ch_data[i];
  end

  rr_mux_reg #(.WIDTH(W), .CHANNELS(CH)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Enable   (Enable),
    .InValid  (InValid),
    .InData   (InData),
    .InReady  (InReady),
    .OutValid (OutValid),
    .OutData  (OutData),
    .OutSel   (OutSel),
    .OutReady (OutReady)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic int exp_grant_idx();
    int start;
    if (Reset_n !== 1'b1 || Enable !== 1'b1) return -1;
    if (m_valid && OutReady !== 1'b1) return -1;
`ifdef RR_MUX_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < CH; k++) begin
      if (InValid[(start + k) % CH] === 1'b1) return (start + k) % CH;
    end
    return -1;
  endfunction

  function automatic logic [CH-1:0] exp_ready();
    int g;
    g = exp_grant_idx();
    return (g < 0) ? '0 : (CH'(1) << g);
  endfunction

  // Advance one clock, updating the model from the inputs seen just before the edge.
  task automatic tick();
    int           g;
    logic         rst_seen;
    logic         rdy_seen;
    logic [W-1:0] d;
    g        = exp_grant_idx();
    rst_seen = Reset_n;
    rdy_seen = OutReady;
    d        = (g >= 0) ? ch_data[g] : '0;
    @(posedge Clock);
    if (!rst_seen) begin
      m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1; m_data = d; m_sel = 2'(g); m_ptr = (g + 1) % CH;
    end else if (m_valid && rdy_seen) begin
      m_valid = 1'b0; m_data = '0;
    end
    #1;
  endtask

  task automatic reset_dut();
    Reset_n = 1'b0; Enable = 1'b1; InValid = '0; OutReady = 1'b1;
    #1;
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Enable = 1'b1; InValid = '1; OutReady = 1'b1;
    for (int i = 0; i < CH; i++) ch_data[i] = $urandom;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (InReady !== 4'b0000) begin
        $display("FAIL reset_inready cyc=%0d got=%b want=0000", c, InReady); failures++;
      end
      tick();
      checks++;
      if (OutValid !== 1'b0 || OutData !== '0 || OutSel !== 2'd0) begin
        $display("FAIL reset_out cyc=%0d got v=%b d=%h s=%0d want v=0 d=0 s=0", c, OutValid, OutData, OutSel);
        failures++;
      end
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_single();
    reset_dut();
    InValid = 4'b0100; ch_data[2] = 32'hDEAD_BEEF; OutReady = 1'b1;
    #1;
    checks++;
    if (InReady !== 4'b0100) begin
      $display("FAIL single_inready got=%b want=0100", InReady); failures++;
    end
    tick();
    InValid = '0;
    checks++;
    if (OutValid !== 1'b1 || OutData !== 32'hDEAD_BEEF || OutSel !== 2'd2) begin
      $display("FAIL single_out got v=%b d=%h s=%0d want v=1 d=deadbeef s=2", OutValid, OutData, OutSel);
      failures++;
    end
    tick();
    checks++;
    if (OutValid !== 1'b0 || OutData !== '0 || OutSel !== 2'd2) begin
      $display("FAIL single_drain got v=%b d=%h s=%0d want v=0 d=0 s=2", OutValid, OutData, OutSel);
      failures++;
    end
  endtask

  task automatic test_round_robin();
    int seq [5];
`ifdef RR_MUX_FIXED_PRIO_EN
    seq = '{0, 0, 0, 0, 0};
`else
    seq = '{0, 1, 2, 3, 0};
`endif
    reset_dut();
    InValid = 4'b1111; OutReady = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < CH; i++) ch_data[i] = $urandom;
      #1;
      checks++;
      if (InReady !== (CH'(1) << seq[c])) begin
        $display("FAIL rr_grant cyc=%0d got=%b want ch%0d", c, InReady, seq[c]); failures++;
      end
      tick();
      checks++;
      if (OutValid !== 1'b1 || OutSel !== 2'(seq[c]) || OutData !== m_data) begin
        $display("FAIL rr_out cyc=%0d got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 c, OutValid, OutSel, OutData, seq[c], m_data);
        failures++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    int           nxt;
    reset_dut();
    InValid = 4'b0010; ch_data[1] = $urandom; held = ch_data[1]; OutReady = 1'b1;
    #1;
    checks++;
    if (InReady !== 4'b0010) begin
      $display("FAIL bp_load got=%b want=0010", InReady); failures++;
    end
    tick();
    OutReady = 1'b0; InValid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < CH; i++) ch_data[i] = $urandom;
      #1;
      checks++;
      if (InReady !== 4'b0000) begin
        $display("FAIL bp_stall_inready cyc=%0d got=%b want=0000", c, InReady); failures++;
      end
      tick();
      checks++;
      if (OutValid !== 1'b1 || OutSel !== 2'd1 || OutData !== held) begin
        $display("FAIL bp_stall_out cyc=%0d got v=%b s=%0d d=%h want v=1 s=1 d=%h",
                 c, OutValid, OutSel, OutData, held);
        failures++;
      end
    end
`ifdef RR_MUX_FIXED_PRIO_EN
    nxt = 0;
`else
    nxt = 2;
`endif
    OutReady = 1'b1;
    #1;
    checks++;
    if (InReady !== (CH'(1) << nxt)) begin
      $display("FAIL bp_release_inready got=%b want ch%0d", InReady, nxt); failures++;
    end
    held = ch_data[nxt];
    tick();
    checks++;
    if (OutValid !== 1'b1 || OutSel !== 2'(nxt) || OutData !== held) begin
      $display("FAIL bp_release_out got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
               OutValid, OutSel, OutData, nxt, held);
      failures++;
    end
  endtask

  task automatic test_enable();
    logic [CH-1:0] want;
    reset_dut();
    InValid = 4'b0001; ch_data[0] = $urandom; OutReady = 1'b1;
    #1;
    tick();
    Enable = 1'b0; InValid = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (InReady !== 4'b0000) begin
        $display("FAIL en_off_inready cyc=%0d got=%b want=0000", c, InReady); failures++;
      end
      tick();
      checks++;
      if (OutValid !== 1'b0 || OutData !== '0 || OutSel !== 2'd0) begin
        $display("FAIL en_off_drain cyc=%0d got v=%b d=%h s=%0d want v=0 d=0 s=0", c, OutValid, OutData, OutSel);
        failures++;
      end
    end
`ifdef RR_MUX_FIXED_PRIO_EN
    want = 4'b0001;
`else
    want = 4'b0010;
`endif
    Enable = 1'b1;
    #1;
    checks++;
    if (InReady !== want) begin
      $display("FAIL en_resume_ptr got=%b want=%b", InReady, want); failures++;
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    InValid = 4'b0100; ch_data[2] = $urandom; OutReady = 1'b1;
    #1;
    tick();
    InValid = 4'b1111; OutReady = 1'b0;
    #1;
    tick();
    Reset_n = 1'b0;
    #1;
    checks++;
    if (InReady !== 4'b0000) begin
      $display("FAIL rst_stall_inready got=%b want=0000", InReady); failures++;
    end
    tick();
    checks++;
    if (OutValid !== 1'b0 || OutData !== '0 || OutSel !== 2'd0) begin
      $display("FAIL rst_stall_out got v=%b d=%h s=%0d want v=0 d=0 s=0", OutValid, OutData, OutSel);
      failures++;
    end
    Reset_n = 1'b1; OutReady = 1'b1;
    #1;
    checks++;
    if (InReady !== 4'b0001) begin
      $display("FAIL rst_stall_ptr got=%b want=0001", InReady); failures++;
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      Reset_n  = ($urandom_range(0, 63) != 0);
      Enable   = ($urandom_range(0, 7) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      InValid  = CH'($urandom);
      for (int i = 0; i < CH; i++) ch_data[i] = $urandom;
      #1;
      checks++;
      if (InReady !== exp_ready()) begin
        $display("FAIL rand_inready cyc=%0d got=%b want=%b", c, InReady, exp_ready()); failures++;
      end
      tick();
      checks++;
      if (OutValid !== m_valid || OutData !== m_data || OutSel !== m_sel) begin
        $display("FAIL rand_out cyc=%0d got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                 c, OutValid, OutData, OutSel, m_valid, m_data, m_sel);
        failures++;
      end
    end
    Reset_n = 1'b1; Enable = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0; Enable = 1'b1; InValid = '0; OutReady = 1'b1;
    for (int i = 0; i < CH; i++) ch_data[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
